// File: rtl/trace_unloader_pkg.sv
// Shared types and width helpers for the trace drain path.
package trace_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  // Word counts need one extra bit so a completely full buffer is representable.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int bit_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/trace_unloader_if.sv
// Trace-buffer / TAP side signals of the trace unloader.
interface trace_unloader_if #(
  parameter int Fpay  = 32,
  parameter int TB_AW = 9
);
  logic                                      start;
  logic                                      abort;
  logic [trace_dbg_pkg::cnt_w(TB_AW)-1:0]    tb_count;
  logic                                      tb_rd;
  logic [Fpay-1:0]                           tb_dout;
  logic                                      shift_en;
  logic                                      tdo;
  logic                                      busy;
  logic                                      done;
  logic [trace_dbg_pkg::cnt_w(TB_AW)-1:0]    words_sent;

  modport master (
    input  start, abort, tb_count, tb_dout, shift_en,
    output tb_rd, tdo, busy, done, words_sent
  );

  modport slave (
    output start, abort, tb_count, tb_dout, shift_en,
    input  tb_rd, tdo, busy, done, words_sent
  );
endinterface

// File: rtl/trace_unloader_piso.sv
// Parallel-in serial-out word register, LSB first, with bit position tracking.
module trace_piso
  import trace_dbg_pkg::*;
#(
  parameter int Fpay = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [Fpay-1:0] din,
  output logic            sout,
  output logic            last
);
  localparam int BW = bit_w(Fpay);
  localparam logic [BW-1:0] LAST_BIT = BW'(Fpay - 1);

  logic [Fpay-1:0] r_sr;
  logic [BW-1:0]   r_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_bit <= '0;
    end else if (load) begin
      r_sr  <= din;
      r_bit <= '0;
    end else if (shift) begin
      r_sr  <= {1'b0, r_sr[Fpay-1:1]};
      // Explicit wrap keeps non-power-of-two widths correct.
      r_bit <= last ? '0 : r_bit + BW'(1);
    end
  end

  assign sout = r_sr[0];
  assign last = (r_bit == LAST_BIT);
endmodule

// File: rtl/trace_unloader.sv
// Drains the trace buffer word by word onto the TAP data-register line.
module trace_unloader
  import trace_dbg_pkg::*;
#(
  parameter int Fpay   = 32,
  parameter int TB_AW  = 9,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  trace_unloader_if.master bus
);
  localparam int CW = cnt_w(TB_AW);
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  state_t        r_state;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] r_words_sent;
  logic [1:0]    r_lat;
  logic          r_tb_rd;
  logic          r_busy;
  logic          r_done;

  logic w_load;
  logic w_shift;
  logic w_sout;
  logic w_last;

  assign w_load  = (r_state == WAIT)  && !bus.abort && (r_lat == 2'd1);
  assign w_shift = (r_state == SHIFT) && !bus.abort && bus.shift_en;

  trace_piso #(.Fpay(Fpay)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (bus.tb_dout),
    .sout  (w_sout),
    .last  (w_last)
  );

  // tb_rd and done are set on entry to REQ/DONE so they are registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_words_sent <= '0;
      r_lat        <= '0;
      r_tb_rd      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_tb_rd <= 1'b0;
      r_done  <= 1'b0;
      if (r_state != IDLE && bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_remaining  <= bus.tb_count;
              r_words_sent <= '0;
              r_busy       <= 1'b1;
              if (bus.tb_count == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= REQ;
                r_tb_rd <= 1'b1;
              end
            end
          end
          REQ: begin
            r_lat   <= LAT_INIT;
            r_state <= WAIT;
          end
          WAIT: begin
            r_lat <= r_lat - 2'd1;
            if (r_lat == 2'd1) r_state <= SHIFT;
          end
          SHIFT: begin
            if (bus.shift_en && w_last) begin
              r_words_sent <= r_words_sent + CW'(1);
              r_remaining  <= r_remaining - CW'(1);
              if (r_remaining == CW'(1)) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= REQ;
                r_tb_rd <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tb_rd      = r_tb_rd;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.words_sent = r_words_sent;
  assign bus.tdo        = (r_state == SHIFT) && w_sout;
endmodule

// File: doc/trace_unloader.md
Name: trace_unloader

Overview:
- Drain-side controller for the debug trace buffer.
- On a dump request it snapshots the buffer's word count, then issues one-cycle read pulses to the buffer and captures each returned word.
- Each word is serialized LSB-first onto a JTAG-style data-register line, advancing only on cycles where the TAP asserts shift enable.
- Sits between the trace buffer and the debug TAP in the DfD subsystem.

Parameters:
- Fpay, 32, trace word width in bits; must equal the trace buffer data width.
- TB_AW, 9, trace buffer address width; buffer holds 2^TB_AW words.
- RD_LAT, 1, cycles from a buffer read pulse to valid buffer data; legal range 1..3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  dump request; pulse, sampled only in IDLE
- abort  in  1  terminate the dump; sampled in every non-IDLE state
- tb_count  in  TB_AW+1  current number of valid words in the trace buffer
- tb_rd  out  1  read pulse to the trace buffer; advances its read pointer
- tb_dout  in  Fpay  trace buffer read data, valid RD_LAT cycles after tb_rd
- shift_en  in  1  TAP in Shift-DR, already synchronous to clk; one bit per asserted cycle
- tdo  out  1  serial data out
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- words_sent  out  TB_AW+1  count of words fully shifted out in the current or last dump

Behaviour:
- Reset (async, at any time, including mid-dump): state=IDLE; tb_rd=0; tdo=0; busy=0; done=0; words_sent=0; shift register=0; bit counter=0; latched count=0; latency counter=0.
- State IDLE:
  - start=1 → latch remaining=tb_count, clear words_sent, set busy.
  - If tb_count==0 → DONE, otherwise → REQ.
- State REQ (exactly 1 cycle):
  - tb_rd=1 → WAIT; latency counter loaded with RD_LAT.
- State WAIT:
  - Decrement the latency counter each cycle; when it reaches 0, capture tb_dout into the shift register → SHIFT.
  - With RD_LAT=1, capture occurs on the cycle after REQ.
- State SHIFT:
  - tdo = shift_reg[0] combinationally.
  - On each cycle with shift_en=1: shift right (MSB filled with 0) and increment the bit counter.
  - When shift_en=1 with bit counter == Fpay-1:
    - words_sent += 1; remaining -= 1.
    - If remaining was 1 → DONE, else → REQ.
  - shift_en=0 stalls the machine indefinitely with no state change.
- State DONE (1 cycle): done=1, busy=0 on the following cycle → IDLE.
- tdo is 0 in every state other than SHIFT.
- tb_rd is never asserted more than once per word and never outside REQ.
- Total reads issued = latched tb_count unless the dump is aborted.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - No done pulse; busy drops; words_sent holds its value.
  - An outstanding read's data is discarded.
  - abort takes priority over shift and transition conditions.
- start while busy is ignored.
- tb_count changing during a dump is ignored; only the value latched at start is used.
- Width rules:
  - remaining and words_sent are TB_AW+1 bits, so a full buffer (2^TB_AW) is representable; no wrap.
  - Bit counter is $clog2(Fpay) bits.

Decomposition:
- Package trace_dbg_pkg contains:
  - state enum (IDLE, REQ, WAIT, SHIFT, DONE);
  - localparam functions for the count width (TB_AW+1) and bit-counter width ($clog2(Fpay)).
- One sub-module, trace_piso: Fpay-bit parallel-in serial-out register.
  - Inputs: load, shift, din.
  - Outputs: sout, last (bit counter == Fpay-1).
  - Async active-high reset.
- The top level holds the FSM, the counters and the latency timer.

Test Plan:
- Reset mid-SHIFT: with Fpay=32, after 5 bits of word 0xA5A5A5A5, assert reset → tdo=0, busy=0, tb_rd=0 immediately; after release, start with tb_count=1 → full word 0xA5A5A5A5 shifted LSB-first (1,0,1,0,0,1,0,1,…).
- Basic dump: tb_count=3, buffer holds 0x00000001, 0x80000000, 0xDEADBEEF, shift_en held high → exactly 3 tb_rd pulses, 96 tdo bits matching the words LSB-first, done pulses once, words_sent=3.
- Empty buffer: tb_count=0, start → no tb_rd, done one cycle after start acceptance, words_sent=0.
- Shift stall: tb_count=1, word 0x0000000F, shift_en toggled 1-0-0-1-… → tdo holds during low cycles; after 32 enabled cycles the sequence is 1,1,1,1 followed by 28 zeros; done pulses.
- Abort: tb_count=4, assert abort after word 1 has completed and 10 bits of word 2 have shifted → IDLE next cycle, no done, words_sent=1, no further tb_rd.
- Full buffer with RD_LAT=2: TB_AW=4, tb_count=16 → 16 reads with each capture 2 cycles after tb_rd, words_sent=16 (5-bit value 10000), no counter wrap.
